// File: rtl/ce_sched_pkg.sv
// Shared types and helpers for the chip-enable frame scheduler.
package ce_sched_pkg;

    // Scheduler phases: waiting for a request, driving ce, enforcing spacing.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRAME = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Widest requester vector the onehot helper can produce.
    localparam int MAX_REQ = 32;

    // Counter width wide enough to hold the longer of the frame and gap counts.
    function automatic int cnt_width(input int frame_len, input int gap_len);
        int longest;
        longest = (frame_len > gap_len) ? frame_len : gap_len;
        return $clog2(longest + 1);
    endfunction

    // One-hot vector with bit idx set; callers size-cast to their own width.
    function automatic logic [MAX_REQ-1:0] onehot(input int idx);
        return MAX_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/ce_frame_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, with wrap.
module rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] winner,
    output logic             valid
);

    // Scan requesters starting at ptr; the first hit wins.
    always_comb begin : arb_search
        logic [IDX_W-1:0] idx;
        // NOTE: every output of a combinational block gets a default before any
        // conditional assignment, otherwise synthesis infers a latch to hold it.
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = IDX_W'((int'(ptr) + i) % NREQ);
            if (!valid && req[idx]) begin
                valid  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/ce_frame_sched.sv
// Round-robin scheduler handing out fixed-length ce frames with a mandatory gap.
module ce_frame_sched #(
    parameter int NREQ      = 4,
    parameter int FRAME_LEN = 16,
    parameter int GAP_LEN   = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic                    abort,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] owner,
    output logic                    ce,
    output logic                    frame_done,
    output logic                    busy
);
    import ce_sched_pkg::*;

    localparam int IDX_W      = $clog2(NREQ);
    localparam int CNT_W      = cnt_width(FRAME_LEN, GAP_LEN);
    localparam int FRAME_LAST = FRAME_LEN - 1;
    // GAP is never entered when GAP_LEN is zero; clamp so the constant stays legal.
    localparam int GAP_LAST   = (GAP_LEN > 0) ? GAP_LEN - 1 : 0;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic              ce_q, ce_d;
    logic              frame_done_q, frame_done_d;

    logic [IDX_W-1:0]  arb_winner;
    logic              arb_valid;

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req    (req),
        .ptr    (ptr_q),
        .winner (arb_winner),
        .valid  (arb_valid)
    );

    // Next-state and next-output logic for the IDLE/FRAME/GAP sequencer.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ptr_d        = ptr_q;
        gnt_d        = gnt_q;
        owner_d      = owner_q;
        ce_d         = ce_q;
        frame_done_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    state_d = FRAME;
                    cnt_d   = '0;
                    gnt_d   = NREQ'(onehot(int'(arb_winner)));
                    owner_d = arb_winner;
                    ce_d    = 1'b1;
                    ptr_d   = (int'(arb_winner) == NREQ - 1) ? '0 : arb_winner + 1'b1;
                end
            end

            FRAME: begin
                // Reaching the last cycle wins over a simultaneous abort.
                if ((cnt_q == CNT_W'(FRAME_LAST)) || abort) begin
                    state_d      = (GAP_LEN > 0) ? GAP : IDLE;
                    cnt_d        = '0;
                    gnt_d        = '0;
                    owner_d      = '0;
                    ce_d         = 1'b0;
                    frame_done_d = (cnt_q == CNT_W'(FRAME_LAST));
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            GAP: begin
                if (cnt_q == CNT_W'(GAP_LAST)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                gnt_d   = '0;
                owner_d = '0;
                ce_d    = 1'b0;
            end
        endcase
    end

    // State, counter, pointer and registered outputs; reset drops ce at once.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            ptr_q        <= '0;
            gnt_q        <= '0;
            owner_q      <= '0;
            ce_q         <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ptr_q        <= ptr_d;
            gnt_q        <= gnt_d;
            owner_q      <= owner_d;
            ce_q         <= ce_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign gnt        = gnt_q;
    assign owner      = owner_q;
    assign ce         = ce_q;
    assign frame_done = frame_done_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_ce_frame_sched.sv
// Self-checking bench: timestamp-based reference model plus directed scenarios
// and a randomized run, on a default instance and a FRAME_LEN=1/GAP_LEN=0 corner.
module tb_ce_frame_sched;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] req   = '0;
    logic       abort = 1'b0;
    logic [3:0] req_c = '0;
    logic       abort_c = 1'b0;

    logic [3:0] gnt, gnt_c;
    logic [1:0] owner, owner_c;
    logic       ce, ce_c, frame_done, frame_done_c, busy, busy_c;

    ce_frame_sched #(.NREQ(4), .FRAME_LEN(16), .GAP_LEN(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .req(req), .abort(abort),
        .gnt(gnt), .owner(owner), .ce(ce), .frame_done(frame_done), .busy(busy)
    );

    ce_frame_sched #(.NREQ(4), .FRAME_LEN(1), .GAP_LEN(0)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .req(req_c), .abort(abort_c),
        .gnt(gnt_c), .owner(owner_c), .ce(ce_c), .frame_done(frame_done_c), .busy(busy_c)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int t        = 0;

    // Reference model: each frame described by the edge it was granted on, the
    // edge ce drops on and the edge after which the scheduler is idle again.
    int f_start[2], f_end[2], idle_from[2], m_owner[2], m_ptr[2], grants[2];
    bit done_ok[2];

    // Observation logs of the default instance for the directed checks.
    int   runs[$];
    int   owners_log[$];
    int   done_cnt;
    int   ce_run;
    logic prev_ce;
    logic c_ce_hist[$];
    logic c_done_hist[$];

    function automatic int fl_of(input int m);
        return (m == 0) ? 16 : 1;
    endfunction

    function automatic int gp_of(input int m);
        return (m == 0) ? 1 : 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: t=%0d got 0x%0h expected 0x%0h", tag, t, obs, exp);
        end
    endtask

    task automatic model_reset(input int m);
        f_start[m]   = -1;
        f_end[m]     = -1;
        idle_from[m] = -1;
        m_owner[m]   = 0;
        m_ptr[m]     = 0;
        grants[m]    = 0;
        done_ok[m]   = 1'b0;
    endtask

    // Apply the inputs sampled at edge tt to model m.
    task automatic model_edge(input int m, input int tt, input logic [3:0] r, input logic ab);
        int w;
        if (ab && tt > f_start[m] && tt < f_end[m]) begin
            f_end[m]     = tt;
            done_ok[m]   = 1'b0;
            idle_from[m] = tt + gp_of(m);
        end else if (tt > idle_from[m] && r != 4'b0) begin
            w = -1;
            for (int i = 0; i < 4; i++) begin
                if (w < 0 && r[(m_ptr[m] + i) % 4]) w = (m_ptr[m] + i) % 4;
            end
            m_owner[m]   = w;
            m_ptr[m]     = (w + 1) % 4;
            f_start[m]   = tt;
            f_end[m]     = tt + fl_of(m);
            idle_from[m] = tt + fl_of(m) + gp_of(m);
            done_ok[m]   = 1'b1;
            grants[m]++;
        end
    endtask

    task automatic model_expect(input int m, output logic e_ce, output logic [3:0] e_gnt,
                                output logic [1:0] e_own, output logic e_done, output logic e_busy);
        e_ce   = (t >= f_start[m]) && (t < f_end[m]);
        e_gnt  = e_ce ? 4'(1 << m_owner[m]) : 4'b0;
        e_own  = e_ce ? 2'(m_owner[m]) : 2'b0;
        e_done = done_ok[m] && (t == f_end[m]);
        e_busy = (t >= f_start[m]) && (t < idle_from[m]);
    endtask

    task automatic compare_all();
        logic e_ce, e_done, e_busy;
        logic [3:0] e_gnt;
        logic [1:0] e_own;
        model_expect(0, e_ce, e_gnt, e_own, e_done, e_busy);
        check("ce", ce, e_ce);
        check("gnt", gnt, e_gnt);
        check("owner", owner, e_own);
        check("frame_done", frame_done, e_done);
        check("busy", busy, e_busy);
        model_expect(1, e_ce, e_gnt, e_own, e_done, e_busy);
        check("ce_c", ce_c, e_ce);
        check("gnt_c", gnt_c, e_gnt);
        check("owner_c", owner_c, e_own);
        check("frame_done_c", frame_done_c, e_done);
        check("busy_c", busy_c, e_busy);
    endtask

    task automatic clear_logs();
        runs.delete();
        owners_log.delete();
        c_ce_hist.delete();
        c_done_hist.delete();
        done_cnt = 0;
        ce_run   = 0;
        prev_ce  = ce;
    endtask

    // One clock: drive on the falling edge, model the rising edge, sample 1 ns later.
    task automatic step(input logic [3:0] r, input logic ab, input logic [3:0] rc, input logic abc);
        @(negedge clk);
        req = r; abort = ab; req_c = rc; abort_c = abc;
        @(posedge clk);
        t++;
        if (rst_n) begin
            model_edge(0, t, r, ab);
            model_edge(1, t, rc, abc);
        end
        #1;
        compare_all();
        if (ce && !prev_ce) owners_log.push_back(int'(owner));
        if (ce) ce_run++;
        else if (prev_ce) begin
            runs.push_back(ce_run);
            ce_run = 0;
        end
        if (frame_done) done_cnt++;
        prev_ce = ce;
        c_ce_hist.push_back(ce_c);
        c_done_hist.push_back(frame_done_c);
    endtask

    // Asynchronous reset from wherever the clock currently is.
    task automatic do_reset();
        rst_n = 1'b0;
        model_reset(0);
        model_reset(1);
        #1;
        check("rst_ce", ce, 1'b0);
        check("rst_gnt", gnt, 4'b0);
        check("rst_owner", owner, 2'b0);
        check("rst_done", frame_done, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ce_c", ce_c, 1'b0);
        repeat (2) step(4'b0, 1'b0, 4'b0, 1'b0);
        rst_n = 1'b1;
        clear_logs();
    endtask

    task automatic check_owners(input string tag, input int exp[$]);
        check({tag, "_ngrants"}, owners_log.size() >= exp.size(), 1'b1);
        for (int i = 0; i < exp.size(); i++) begin
            if (i < owners_log.size()) check({tag, "_owner"}, owners_log[i], exp[i]);
        end
    endtask

    task automatic check_runs(input string tag, input int exp[$]);
        check({tag, "_nframes"}, runs.size() >= exp.size(), 1'b1);
        for (int i = 0; i < exp.size(); i++) begin
            if (i < runs.size()) check({tag, "_len"}, runs[i], exp[i]);
        end
    endtask

    initial begin
        logic [3:0] pend;
        logic       ab;

        #2;
        do_reset();

        // Single frame from requester 0.
        step(4'b0001, 1'b0, 4'($urandom), 1'b0);
        repeat (24) step(4'b0, 1'b0, 4'($urandom), 1'b0);
        check_runs("single", '{16});
        check_owners("single", '{0});
        check("single_done", done_cnt, 1);

        // Round-robin fairness with everyone requesting.
        do_reset();
        repeat (75) step(4'b1111, 1'b0, 4'($urandom), 1'b0);
        check_owners("rr", '{0, 1, 2, 3, 0});
        check_runs("rr", '{16, 16, 16, 16});

        // Skip and wrap: move ptr to 2 first, then 1010 held.
        do_reset();
        step(4'b0010, 1'b0, 4'b0, 1'b0);
        repeat (20) step(4'b0, 1'b0, 4'b0, 1'b0);
        clear_logs();
        repeat (56) step(4'b1010, 1'b0, 4'($urandom), 1'b0);
        check_owners("wrap", '{3, 1, 3});

        // Abort at frame cycle 5, then abort coinciding with the last cycle.
        do_reset();
        for (int i = 0; i < 50; i++) begin
            ab = ((grants[0] == 1) && (t + 1 == f_start[0] + 6)) ||
                 ((grants[0] == 2) && (t + 1 == f_start[0] + 16));
            step((grants[0] < 2) ? 4'b0011 : 4'b0000, ab, 4'($urandom), 1'b0);
        end
        check_runs("abort", '{6, 16});
        check_owners("abort", '{0, 1});
        check("abort_done", done_cnt, 1);

        // Reset at frame cycle 8 of a frame owned by requester 2.
        do_reset();
        step(4'b0100, 1'b0, 4'b0, 1'b0);
        repeat (8) step(4'b0, 1'b0, 4'b0, 1'b0);
        check("midrst_busy_pre", busy, 1'b1);
        do_reset();
        step(4'b0001, 1'b0, 4'b0, 1'b0);
        repeat (20) step(4'b0, 1'b0, 4'b0, 1'b0);
        check_runs("midrst", '{16});
        check_owners("midrst", '{0});
        check("midrst_done", done_cnt, 1);

        // FRAME_LEN=1, GAP_LEN=0 corner with a held request.
        do_reset();
        repeat (6) step(4'b0, 1'b0, 4'b0001, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("corner_ce", c_ce_hist[i], (i % 2 == 0) ? 1'b1 : 1'b0);
            check("corner_done", c_done_hist[i], (i % 2 == 1) ? 1'b1 : 1'b0);
        end

        // Randomized traffic: level requests held until granted, sporadic aborts.
        do_reset();
        pend = '0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) pend = pend | 4'($urandom_range(0, 15));
            step(pend, $urandom_range(0, 11) == 0, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 3) == 0);
            if (t == f_start[0]) pend[m_owner[0]] = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
